// File: rtl/race_pkg.sv
// Shared dimensions, colours, engine state encoding and the background colour rule for the race game.
package race_pkg;

  localparam int DEF_SCREEN_W    = 160;
  localparam int DEF_SCREEN_H    = 120;
  localparam int DEF_CAR_W       = 8;
  localparam int DEF_CAR_H       = 12;
  localparam int DEF_TRACK_X_MIN = 40;
  localparam int DEF_TRACK_X_MAX = 120;
  localparam int DEF_X_START     = 76;
  localparam int DEF_Y_START     = 100;
  localparam int DEF_X_STEP      = 2;
  localparam int DEF_Y_STEP      = 1;
  localparam int DEF_FRAME_DIV   = 833334;

  localparam logic [2:0] GRASS       = 3'b010;
  localparam logic [2:0] TRACK       = 3'b111;
  localparam logic [2:0] CAR         = 3'b100;
  localparam logic [2:0] TRANSPARENT = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BG,
    S_CAR,
    S_ERASE,
    S_DONE
  } state_t;

  function automatic logic [2:0] bg_colour(input logic [7:0] x,
                                           input int x_min = DEF_TRACK_X_MIN,
                                           input int x_max = DEF_TRACK_X_MAX);
    return (int'(x) >= x_min && int'(x) < x_max) ? TRACK : GRASS;
  endfunction

endpackage

// File: rtl/race_raster_counter.sv
// Rectangle walker: loads an origin and extent, then steps x-inner / y-outer one pixel per step.
module race_raster_counter
  import race_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] org_x,
  input  logic [6:0] org_y,
  input  logic [7:0] ext_w,
  input  logic [6:0] ext_h,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [7:0] dx,
  output logic [6:0] dy,
  output logic       last
);

  logic [7:0] x0;
  logic [7:0] w;
  logic [6:0] y0;
  logic [6:0] h;

  always_ff @(posedge clock) begin
    if (reset) begin
      x0 <= '0;
      y0 <= '0;
      w  <= '0;
      h  <= '0;
      dx <= '0;
      dy <= '0;
    end else if (load) begin
      x0 <= org_x;
      y0 <= org_y;
      w  <= ext_w;
      h  <= ext_h;
      dx <= '0;
      dy <= '0;
    end else if (step) begin
      if (dx == w - 8'd1) begin
        dx <= '0;
        dy <= dy + 7'd1;
      end else begin
        dx <= dx + 8'd1;
      end
    end
  end

  assign x    = x0 + dx;
  assign y    = y0 + dy;
  assign last = (dx == w - 8'd1) && (dy == h - 7'd1);

endmodule

// File: rtl/race_draw_engine.sv
// Race game draw/move engine: rasterises background and car, owns car position, ticks oneframe.
// Optional RACE_CAR_SPRITE_EN: car drawn from a sprite ROM with transparent (000) pixels.
module race_draw_engine
  import race_pkg::*;
#(
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int CAR_W       = DEF_CAR_W,
  parameter int CAR_H       = DEF_CAR_H,
  parameter int TRACK_X_MIN = DEF_TRACK_X_MIN,
  parameter int TRACK_X_MAX = DEF_TRACK_X_MAX,
  parameter int X_START     = DEF_X_START,
  parameter int Y_START     = DEF_Y_START,
  parameter int X_STEP      = DEF_X_STEP,
  parameter int Y_STEP      = DEF_Y_STEP,
  parameter int FRAME_DIV   = DEF_FRAME_DIV
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_race,
  input  logic       resetsignal,
  input  logic       draw_bg,
  input  logic       draw_car,
  input  logic       clear,
  input  logic       drive,
  input  logic       straight,
  input  logic       left,
  input  logic       right,
  output logic       done_bg,
  output logic       done_car,
  output logic       done_erase,
  output logic       oneframe,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  localparam int FRAME_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  state_t             state;
  logic [7:0]         car_x, x_q, cnt_x, cnt_dx, mv_x, eff_x, org_x, ext_w;
  logic [6:0]         car_y, y_q, cnt_y, cnt_dy, mv_y, eff_y, org_y, ext_h;
  logic [2:0]         colour_q, pend_dir, mv_dir, pix_colour;
  logic [FRAME_W-1:0] frame_cnt;
  logic               pend_valid, cnt_last, restart, rastering, car_busy;
  logic               apply_move, load, step, plot;
  logic signed [8:0]  sx, sy, tx, ty;

  race_raster_counter u_counter (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .step  (step),
    .org_x (org_x),
    .org_y (org_y),
    .ext_w (ext_w),
    .ext_h (ext_h),
    .x     (cnt_x),
    .y     (cnt_y),
    .dx    (cnt_dx),
    .dy    (cnt_dy),
    .last  (cnt_last)
  );

  // A drive seen mid-car-raster is parked; IDLE applies the parked move (or a fresh drive, which wins).
  always_comb begin
    restart    = start_race | resetsignal;
    rastering  = state inside {S_BG, S_CAR, S_ERASE};
    car_busy   = state inside {S_CAR, S_ERASE};
    mv_dir     = drive ? {straight, left, right} : pend_dir;
    apply_move = (drive && !car_busy) || (state == S_IDLE && pend_valid);
    sx   = signed'({1'b0, car_x});
    sy   = signed'({2'b00, car_y});
    tx   = sx;
    ty   = sy;
    mv_x = car_x;
    mv_y = car_y;
    if (mv_dir[2]) begin
      ty   = sy - 9'(Y_STEP);
      mv_y = (ty < 0) ? 7'(SCREEN_H - CAR_H) : ty[6:0];
    end else if (mv_dir[1]) begin
      tx   = sx - 9'(X_STEP);
      mv_x = (tx < 9'(TRACK_X_MIN)) ? 8'(TRACK_X_MIN) : tx[7:0];
    end else if (mv_dir[0]) begin
      tx   = sx + 9'(X_STEP);
      mv_x = (tx > 9'(TRACK_X_MAX - CAR_W)) ? 8'(TRACK_X_MAX - CAR_W) : tx[7:0];
    end
    eff_x = apply_move ? mv_x : car_x;
    eff_y = apply_move ? mv_y : car_y;
    org_x = draw_bg ? '0 : eff_x;
    org_y = draw_bg ? '0 : eff_y;
    ext_w = draw_bg ? 8'(SCREEN_W) : 8'(CAR_W);
    ext_h = draw_bg ? 7'(SCREEN_H) : 7'(CAR_H);
    load  = (state == S_IDLE) && !restart && (draw_bg || clear || draw_car);
    step  = rastering && !cnt_last;
  end

`ifdef RACE_CAR_SPRITE_EN
  function automatic logic [2:0] sprite_rom(input int unsigned idx);
    int unsigned col, row;
    col = idx % CAR_W;
    row = idx / CAR_W;
    if ((col == 0 || col == CAR_W - 1) && (row == 0 || row == CAR_H - 1))
      return TRANSPARENT;
    else if (row == 2)
      return 3'b011;
    else
      return CAR;
  endfunction

  logic [2:0] sprite_px;

  always_comb begin
    sprite_px  = sprite_rom(int'(cnt_dy) * CAR_W + int'(cnt_dx));
    pix_colour = (state == S_CAR) ? sprite_px : bg_colour(cnt_x, TRACK_X_MIN, TRACK_X_MAX);
    plot       = rastering && !(state == S_CAR && sprite_px == TRANSPARENT);
  end
`else
  logic unused_offset;

  always_comb begin
    pix_colour    = (state == S_CAR) ? CAR : bg_colour(cnt_x, TRACK_X_MIN, TRACK_X_MAX);
    plot          = rastering;
    unused_offset = ^{cnt_dx, cnt_dy};
  end
`endif

  assign vga_plot   = plot;
  assign vga_x      = plot ? cnt_x : x_q;
  assign vga_y      = plot ? cnt_y : y_q;
  assign vga_colour = plot ? pix_colour : colour_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      car_x      <= 8'(X_START);
      car_y      <= 7'(Y_START);
      pend_valid <= 1'b0;
      pend_dir   <= '0;
      frame_cnt  <= '0;
      oneframe   <= 1'b0;
      done_bg    <= 1'b0;
      done_car   <= 1'b0;
      done_erase <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
    end else begin
      oneframe  <= (frame_cnt == FRAME_W'(FRAME_DIV - 1));
      frame_cnt <= (frame_cnt == FRAME_W'(FRAME_DIV - 1)) ? '0 : frame_cnt + FRAME_W'(1);
      if (plot) begin
        x_q      <= cnt_x;
        y_q      <= cnt_y;
        colour_q <= pix_colour;
      end
      if (restart) begin
        state      <= S_IDLE;
        car_x      <= 8'(X_START);
        car_y      <= 7'(Y_START);
        pend_valid <= 1'b0;
        done_bg    <= 1'b0;
        done_car   <= 1'b0;
        done_erase <= 1'b0;
      end else begin
        if (apply_move) begin
          car_x <= mv_x;
          car_y <= mv_y;
        end
        if (state == S_IDLE) pend_valid <= 1'b0;
        if (drive && car_busy) begin
          pend_valid <= 1'b1;
          pend_dir   <= {straight, left, right};
        end
        case (state)
          S_IDLE: begin
            if (draw_bg)       state <= S_BG;
            else if (clear)    state <= S_ERASE;
            else if (draw_car) state <= S_CAR;
          end
          S_BG: if (cnt_last) begin
            state   <= S_DONE;
            done_bg <= 1'b1;
          end
          S_CAR: if (cnt_last) begin
            state    <= S_DONE;
            done_car <= 1'b1;
          end
          S_ERASE: if (cnt_last) begin
            state      <= S_DONE;
            done_erase <= 1'b1;
          end
          S_DONE: begin
            if ((done_bg && !draw_bg) || (done_car && !draw_car) || (done_erase && !clear)) begin
              state      <= S_IDLE;
              done_bg    <= 1'b0;
              done_car   <= 1'b0;
              done_erase <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_race_draw_engine.sv
// Scoreboard bench for race_draw_engine: driver queues expected pixels/done events, monitor checks them.
module tb_race_draw_engine;

  localparam int K_BG = 0, K_CAR = 1, K_ERASE = 2;

  logic       clock = 0, reset = 1, start_race = 0, resetsignal = 0;
  logic       draw_bg = 0, draw_car = 0, clear = 0;
  logic       drive = 0, straight = 0, left = 0, right = 0;
  logic       done_bg, done_car, done_erase, oneframe, vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  always #5 clock = ~clock;

  race_draw_engine #(.FRAME_DIV(10)) dut (
    .clock(clock), .reset(reset), .start_race(start_race), .resetsignal(resetsignal),
    .draw_bg(draw_bg), .draw_car(draw_car), .clear(clear),
    .drive(drive), .straight(straight), .left(left), .right(right),
    .done_bg(done_bg), .done_car(done_car), .done_erase(done_erase), .oneframe(oneframe),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  typedef struct { int cyc; int x; int y; int c; } pix_t;
  typedef struct { int cyc; int kind; } done_t;

  pix_t  pix_q[$];
  done_t done_q[$];
  int    checks = 0, passes = 0, cyc = 0, since = 0;
  bit    armed = 0;
  int    mx = 76, my = 100;
  bit    pv = 0;
  logic [2:0] pdir = '0;
  logic [2:0] prev_done = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic done_of(input int kind);
    case (kind)
      K_BG:    return done_bg;
      K_CAR:   return done_car;
      default: return done_erase;
    endcase
  endfunction

  always @(posedge clock) begin
    cyc   <= cyc + 1;
    since <= reset ? 0 : since + 1;
  end

  // Monitor: pixels and done rising edges are matched against the scoreboard queues.
  always @(negedge clock) begin
    pix_t  p;
    done_t d;
    logic [2:0] cur;
    if (armed) begin
      chk("oneframe", 64'(oneframe), 64'(since != 0 && since % 10 == 0));
      if (vga_plot) begin
        if (pix_q.size() == 0) chk("unexpected_plot", 64'(vga_plot), 64'(0));
        else begin
          p = pix_q.pop_front();
          chk("pixel{cyc,x,y,c}", {14'd0, 32'(cyc), vga_x, vga_y, vga_colour},
              {14'd0, 32'(p.cyc), 8'(p.x), 7'(p.y), 3'(p.c)});
        end
      end
      cur = {done_erase, done_car, done_bg};
      for (int k = 0; k < 3; k++) begin
        if (cur[k] && !prev_done[k]) begin
          if (done_q.size() == 0) chk("unexpected_done", 64'(cur[k]), 64'(0));
          else begin
            d = done_q.pop_front();
            chk("done_event{cyc,kind}", {32'(cyc), 32'(k)}, {32'(d.cyc), 32'(d.kind)});
            chk("pixels_drained", 64'(pix_q.size()), 64'(0));
          end
        end
      end
      prev_done = cur;
    end
  end

  task automatic model_move(input logic [2:0] d);
    if (d[2]) begin
      my = my - 1;
      if (my < 0) my = 120 - 12;
    end else if (d[1]) begin
      mx = mx - 2;
      if (mx < 40) mx = 40;
    end else if (d[0]) begin
      mx = mx + 2;
      if (mx > 120 - 8) mx = 120 - 8;
    end
  endtask

  task automatic drive_pulse(input logic [2:0] d);
    {straight, left, right} = d;
    drive = 1;
    @(negedge clock);
    drive = 0;
    model_move(d);
  endtask

  task automatic set_cmd(input int kind, input logic v);
    case (kind)
      K_BG:    draw_bg  = v;
      K_CAR:   draw_car = v;
      default: clear    = v;
    endcase
  endtask

  task automatic push_pixels(input int kind, input int s, input int count);
    int ox, oy, w, x, y, c;
    ox = (kind == K_BG) ? 0 : mx;
    oy = (kind == K_BG) ? 0 : my;
    w  = (kind == K_BG) ? 160 : 8;
    for (int i = 0; i < count; i++) begin
      x = ox + i % w;
      y = oy + i / w;
      c = (kind == K_CAR) ? 4 : ((x >= 40 && x < 120) ? 7 : 2);
      pix_q.push_back('{s + i, x, y, c});
    end
  endtask

  // Issues one command from IDLE; optional mid-raster drives (m1/m2) or abort at pixel ab.
  task automatic do_cmd(input int kind, input int m1, input logic [2:0] d1,
                        input int m2, input logic [2:0] d2, input int ab, input bit ab_sel);
    int n, s;
    bit seen;
    n = (kind == K_BG) ? 160 * 120 : 8 * 12;
    s = cyc + 1;
    push_pixels(kind, s, (ab > 0) ? ab : n);
    if (ab == 0) done_q.push_back('{s + n, kind});
    set_cmd(kind, 1);
    seen = 0;
    for (int k = 1; k <= n + 8; k++) begin
      @(negedge clock);
      drive = 0;
      if (done_of(kind)) begin
        seen = 1;
        break;
      end
      if (k == ab) begin
        if (ab_sel) resetsignal = 1; else start_race = 1;
        set_cmd(kind, 0);
        @(negedge clock);
        start_race  = 0;
        resetsignal = 0;
        chk("abort_plot", 64'(vga_plot), 64'(0));
        chk("abort_done", 64'({done_bg, done_car, done_erase}), 64'(0));
        chk("abort_flush", 64'(pix_q.size()), 64'(0));
        mx = 76; my = 100; pv = 0;
        repeat (3) @(negedge clock);
        return;
      end
      if (k == m1) begin
        {straight, left, right} = d1; drive = 1; pv = 1; pdir = d1;
      end
      if (k == m2) begin
        {straight, left, right} = d2; drive = 1; pv = 1; pdir = d2;
      end
    end
    if (!seen) begin
      chk("done_timeout", 64'(done_of(kind)), 64'(1));
      pix_q.delete();
      done_q.delete();
      set_cmd(kind, 0);
      repeat (2) @(negedge clock);
      return;
    end
    repeat ($urandom_range(0, 3)) begin
      @(negedge clock);
      chk("done_hold", 64'(done_of(kind)), 64'(1));
    end
    set_cmd(kind, 0);
    @(negedge clock);
    chk("done_drop", 64'({done_bg, done_car, done_erase}), 64'(0));
    if (pv) begin
      model_move(pdir);
      pv = 0;
    end
    @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, m1, m2, ab;
    reset = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 0;
    chk("reset_outputs", 64'({done_bg, done_car, done_erase, oneframe, vga_x, vga_y, vga_colour, vga_plot}), 64'(0));
    armed = 1;
    @(negedge clock);

    do_cmd(K_BG, 0, 3'b000, 0, 3'b000, 0, 0);
    do_cmd(K_CAR, 0, 3'b000, 0, 3'b000, 0, 0);

    repeat (30) drive_pulse(3'b001);
    do_cmd(K_CAR, 0, 3'b000, 0, 3'b000, 0, 0);
    while (mx > 42) drive_pulse(3'b010);
    do_cmd(K_CAR, 0, 3'b000, 0, 3'b000, 0, 0);
    repeat (2) drive_pulse(3'b010);
    do_cmd(K_CAR, 0, 3'b000, 0, 3'b000, 0, 0);

    while (my > 0) drive_pulse(3'b100);
    do_cmd(K_CAR, 0, 3'b000, 0, 3'b000, 0, 0);
    drive_pulse(3'b100);
    do_cmd(K_ERASE, 0, 3'b000, 0, 3'b000, 0, 0);

    start_race = 1;
    @(negedge clock);
    start_race = 0;
    mx = 76; my = 100;
    do_cmd(K_ERASE, 20, 3'b010, 0, 3'b000, 0, 0);
    do_cmd(K_CAR, 0, 3'b000, 0, 3'b000, 0, 0);

    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(0, 4)) drive_pulse(3'($urandom_range(0, 7)));
      kind = ($urandom_range(0, 1) == 1) ? K_CAR : K_ERASE;
      m1 = 0; m2 = 0; ab = 0;
      if ($urandom_range(0, 4) == 0) ab = $urandom_range(1, 95);
      else begin
        if ($urandom_range(0, 1) == 1) m1 = $urandom_range(1, 90);
        if (m1 > 0 && $urandom_range(0, 1) == 1) m2 = $urandom_range(m1 + 1, 96);
      end
      do_cmd(kind, m1, 3'($urandom_range(0, 7)), m2, 3'($urandom_range(0, 7)), ab,
             1'($urandom_range(0, 1)));
    end

    drive_pulse(3'b001);
    drive_pulse(3'b100);
    do_cmd(K_BG, 0, 3'b000, 0, 3'b000, $urandom_range(100, 500), 0);
    do_cmd(K_CAR, 0, 3'b000, 0, 3'b000, 0, 0);

    repeat (5) @(negedge clock);
    chk("queues_empty", 64'(pix_q.size() + done_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/race_draw_engine.md
Name: race_draw_engine

Overview:
- Datapath/responder for the race game control FSM.
- Accepts level commands draw_bg / draw_car / clear and the drive strobe with a direction.
- Rasterises pixels into the 160x120, 3-bit VGA adapter, owns the car position registers, and returns done_bg / done_car / done_erase plus a free-running oneframe tick.

Parameters:
- SCREEN_W, 160, screen width in pixels
- SCREEN_H, 120, screen height in pixels
- CAR_W, 8, car sprite width
- CAR_H, 12, car sprite height
- TRACK_X_MIN, 40, left track edge (first track column)
- TRACK_X_MAX, 120, right track edge (exclusive)
- X_START, 76, car x after reset/start_race
- Y_START, 100, car y after reset/start_race
- X_STEP, 2, lateral step per left/right move
- Y_STEP, 1, forward step per straight move
- FRAME_DIV, 833334, clock cycles per oneframe tick (50 MHz / 60 Hz)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start_race  in  1  pulse; car to start position, engine to IDLE
- resetsignal  in  1  pulse; same effect as start_race
- draw_bg  in  1  level; paint full background
- draw_car  in  1  level; paint car rectangle
- clear  in  1  level; repaint car rectangle with background
- drive  in  1  pulse; apply one move
- straight  in  1  move direction qualifier
- left  in  1  move direction qualifier
- right  in  1  move direction qualifier
- done_bg  out  1  background complete
- done_car  out  1  car complete
- done_erase  out  1  erase complete
- oneframe  out  1  one-cycle tick every FRAME_DIV cycles
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- vga_plot  out  1  pixel write enable

Behaviour:
- Reset values:
  - all outputs 0
  - car_x = X_START, car_y = Y_START
  - frame counter 0
  - state IDLE
- States: IDLE, BG, CAR, ERASE, DONE.
- IDLE command priority: draw_bg > clear > draw_car.
  - On entry to BG/CAR/ERASE, the raster counters load the region origin: (0,0) for BG, (car_x,car_y) for CAR/ERASE.
- Raster:
  - One pixel per cycle, x inner, y outer; vga_plot=1 every raster cycle.
  - BG: SCREEN_W*SCREEN_H cycles. CAR/ERASE: CAR_W*CAR_H cycles.
  - Command sampled cycle 0; first pixel cycle 1; last pixel cycle N; matching done_* rises cycle N+1.
- DONE:
  - done_* stays high while the originating command stays high.
  - When the command drops, done_* goes low the next cycle and the state returns to IDLE.
  - A command still high is never re-executed.
- Colours:
  - bg_colour(x) = 3'b111 (track) for TRACK_X_MIN <= x < TRACK_X_MAX, else 3'b010 (grass).
  - Car colour 3'b100.
  - ERASE uses bg_colour(x) per pixel.
- Moves, on drive=1, direction priority straight > left > right; none set -> no-op:
  - straight: car_y -= Y_STEP; if result < 0, wrap to SCREEN_H-CAR_H.
  - left: car_x = max(car_x-X_STEP, TRACK_X_MIN).
  - right: car_x = min(car_x+X_STEP, TRACK_X_MAX-CAR_W).
  - Arithmetic uses 9-bit signed intermediates; no unsigned underflow.
- Drive during CAR/ERASE:
  - Latched into a one-deep pending move and applied on the first IDLE cycle.
  - A second drive while pending overwrites the pending move.
- oneframe:
  - Counter 0..FRAME_DIV-1; pulse for one cycle when it equals FRAME_DIV-1, then wraps to 0.
  - Independent of state; only reset clears it.
- start_race/resetsignal mid-raster:
  - Abort the raster, vga_plot=0 next cycle, no done pulse.
  - Reposition car, clear any pending move, go to IDLE.
- vga_x/vga_y/vga_colour hold their last value when vga_plot=0.

Optional Feature:
- RACE_CAR_SPRITE_EN defined:
  - CAR reads a CAR_W*CAR_H x 3-bit sprite ROM indexed by (dy*CAR_W+dx).
  - ROM value 3'b000 is transparent: vga_plot=0 for that pixel, but the cycle is still consumed, so latency is unchanged.
- Undefined: solid 3'b100 rectangle, no ROM instantiated.

Decomposition:
- race_pkg holds:
  - screen/car/track dimension constants
  - colour constants (GRASS, TRACK, CAR, TRANSPARENT)
  - the engine state enum
  - the bg_colour function
- One sub-module, race_raster_counter: loadable x/y origin and extents, step enable, emits current (x,y), offset (dx,dy) and a last-pixel flag. It is used for both BG and car rectangles.

Test Plan:
- reset, then draw_bg held high -> exactly 19200 vga_plot cycles; done_bg at cycle 19201; pixel (39,0)=3'b010, (40,0)=3'b111, (119,0)=3'b111, (120,0)=3'b010; drop draw_bg -> done_bg low next cycle.
- After reset, draw_car -> 96 plots covering x 76..83, y 100..111, colour 3'b100; done_car at cycle 97.
- Saturation: 30 drive pulses with right=1 -> car_x=112; with left=1 from 42 -> 40, then stays 40.
- Wrap: car_y=0, drive with straight=1 -> car_y=108.
- Pending move: drive+left mid-ERASE -> car_x unchanged until IDLE, then 74; a subsequent draw_car starts at x=74.
- Frame tick and abort: FRAME_DIV=10 override -> oneframe high on cycles 10, 20, 30 after reset; start_race during BG -> vga_plot 0 next cycle, no done_bg, car at (76,100).
